bus_arbiter_rr: RTL

Parametrised round-robin bus arbiter for the multiprocessor coherence platform. N processors raise a request and receive a one-hot grant, and the winner's word is registered onto the shared bus. Bus width and processor count are parameters, and a release/re-arbitrate state machine replaces fixed selection. An optional hold-timeout preempts an owner that keeps the bus too long.

---
 rtl/bus_arbiter_rr_if.sv | 16 +
 rtl/bus_arbiter_rr.sv | 104 ++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: processor request/data lines and the arbiter's grant and shared-bus outputs.
interface bus_arbiter_rr_if #(
  parameter int WIDTH = 16,
  parameter int N_PROC = 3,
  parameter int IDW = $clog2(N_PROC)
);
  logic [N_PROC-1:0] req;
  logic [N_PROC*WIDTH-1:0] bus_in;
  logic [N_PROC-1:0] grant;
  logic [IDW-1:0] owner;
  logic [WIDTH-1:0] bus;
  logic bus_valid;
  logic preempt;
  modport master (output req, bus_in, input grant, owner, bus, bus_valid, preempt);
  modport slave (input req, bus_in, output grant, owner, bus, bus_valid, preempt);
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: round-robin bus arbiter with registered shared bus.
// Define BUS_ARB_TIMEOUT_EN to build the MAX_HOLD forced-release (preempt) logic.
module bus_arbiter_rr #(
  parameter int WIDTH = 16,
  parameter int N_PROC = 3,
  parameter int IDW = $clog2(N_PROC),
  parameter int MAX_HOLD = 8
) (
  input logic clock,
  input logic reset,
  bus_arbiter_rr_if.slave bus_if
);
  typedef enum logic {IDLE, OWNED} state_t;
  state_t state_q, state_d;
  logic [N_PROC-1:0] grant_q, grant_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [WIDTH-1:0] bus_q, bus_d;
  logic valid_q, valid_d;
  logic preempt_q, preempt_d;
  logic [IDW-1:0] win, idx;
  logic [WIDTH-1:0] words [N_PROC];
  logic any_req, req_own, timeout, rel;
  for (genvar i = 0; i < N_PROC; i++) begin : g_word
    assign words[i] = bus_if.bus_in[i*WIDTH +: WIDTH];
  end
  assign any_req = |bus_if.req;
  assign req_own = bus_if.req[owner_q];
  assign rel = !req_own || timeout;
  // Scan downward so the nearest requester after last_q is the final assignment.
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N_PROC; k >= 1; k--) begin
      idx = IDW'((int'(last_q) + k) % N_PROC);
      win = bus_if.req[idx] ? idx : win;
    end
  end
`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign timeout = cnt_q == CW'(MAX_HOLD);
  always_comb begin
    cnt_d = (state_q == IDLE) ? (any_req ? CW'(1) : '0) : (rel ? '0 : cnt_q + CW'(1));
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  localparam int unused_max_hold = MAX_HOLD;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (any_req ? OWNED : IDLE) : (rel ? IDLE : OWNED);
  end
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    last_d = last_q;
    bus_d = bus_q;
    valid_d = valid_q;
    preempt_d = 1'b0;
    if (state_q == IDLE && any_req) begin
      grant_d = N_PROC'(1) << win;
      owner_d = win;
      last_d = win;
      bus_d = words[win];
      valid_d = 1'b1;
    end else if (state_q == OWNED && rel) begin
      grant_d = '0;
      valid_d = 1'b0;
      preempt_d = req_own;
    end else if (state_q == OWNED) begin
      bus_d = words[owner_q];
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      grant_q <= '0;
      owner_q <= '0;
      last_q <= IDW'(N_PROC - 1);
      bus_q <= '0;
      valid_q <= 1'b0;
      preempt_q <= 1'b0;
    end else begin
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q <= last_d;
      bus_q <= bus_d;
      valid_q <= valid_d;
      preempt_q <= preempt_d;
    end
  end
  assign bus_if.grant = grant_q;
  assign bus_if.owner = owner_q;
  assign bus_if.bus = bus_q;
  assign bus_if.bus_valid = valid_q;
  assign bus_if.preempt = preempt_q;
endmodule
